// File: rtl/pipe_dbg_pkg.sv
// Shared types for the Pipe_CPU bring-up run/dump controller.
// The dump-beat layout fixes the register index and data widths used by run_dump_ctrl.
package pipe_dbg_pkg;

    localparam int DBG_DATA_W = 32;
    localparam int DBG_ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DUMP_RD,
        DUMP_OUT,
        DONE
    } dbg_state_t;

    typedef struct packed {
        logic [DBG_ADDR_W-1:0] idx;
        logic [DBG_DATA_W-1:0] data;
    } dump_beat_t;

endpackage

// File: rtl/pc_stall_detect.sv
// Detects a halted CPU: counts consecutive cycles in which the fetch PC repeats
// and flags the cycle in which that count reaches STALL_LIMIT.
module pc_stall_detect #(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            active_i,
    input  logic            halt_en_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            halt_o
);

    localparam int STUCK_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STUCK_W-1:0] LIMIT = STUCK_W'(STALL_LIMIT);

    logic [PC_W-1:0]    prev_pc_reg;
    logic               prev_vld_reg;
    logic [STUCK_W-1:0] stuck_reg;
    logic [STUCK_W-1:0] stuck_next;

    // No previous PC exists in the first active cycle, so it never counts as a repeat.
    always_comb begin
        stuck_next = '0;
        if (prev_vld_reg && (pc_i == prev_pc_reg)) begin
            stuck_next = (stuck_reg == LIMIT) ? stuck_reg : stuck_reg + 1'b1;
        end
    end

    assign halt_o = halt_en_i && active_i && (stuck_next == LIMIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev_pc_reg  <= '0;
            prev_vld_reg <= 1'b0;
            stuck_reg    <= '0;
        end else if (clear_i) begin
            prev_vld_reg <= 1'b0;
            stuck_reg    <= '0;
        end else if (active_i) begin
            prev_pc_reg  <= pc_i;
            prev_vld_reg <= 1'b1;
            stuck_reg    <= stuck_next;
        end
    end

endmodule

// File: rtl/run_dump_ctrl.sv
// Run controller for Pipe_CPU bring-up: releases the CPU from reset for one run,
// ends it on a cycle limit or a stuck PC, then streams the register file over valid/ready.
module run_dump_ctrl
    import pipe_dbg_pkg::*;
#(
    parameter int DATA_W      = DBG_DATA_W,
    parameter int NREG        = 32,
    parameter int ADDR_W      = DBG_ADDR_W,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 100,
    parameter int STALL_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              halt_en_i,
    input  logic [CNT_W-1:0]  cycle_limit_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              cpu_rst_o,
    output logic [ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic              done_o,
    output logic              timeout_o
);

    localparam logic [CNT_W-1:0]  DEFAULT_LIMIT = CNT_W'(MAX_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX      = ADDR_W'(NREG - 1);

    dbg_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  limit_reg;
    logic [ADDR_W-1:0] idx_reg;
    dump_beat_t        beat_reg;
    logic              valid_reg;
    logic              cpu_rst_reg;
    logic              done_reg;
    logic              timeout_reg;

    logic [CNT_W-1:0]  cnt_next;
    logic              limit_hit;
    logic              start_accept;
    logic              halt_det;

    assign start_accept = start_i && ((state_reg == IDLE) || (state_reg == DONE));
    assign cnt_next     = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
    assign limit_hit    = (cnt_next == limit_reg);

    pc_stall_detect #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (start_accept),
        .active_i  (state_reg == RUN),
        .halt_en_i (halt_en_i),
        .pc_i      (pc_i),
        .halt_o    (halt_det)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            limit_reg   <= '0;
            idx_reg     <= '0;
            beat_reg    <= '0;
            valid_reg   <= 1'b0;
            cpu_rst_reg <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_i) begin
                        limit_reg   <= (cycle_limit_i == '0) ? DEFAULT_LIMIT : cycle_limit_i;
                        cnt_reg     <= '0;
                        done_reg    <= 1'b0;
                        timeout_reg <= 1'b0;
                        cpu_rst_reg <= 1'b1;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_next;
                    // The limit takes precedence when both end conditions fire together.
                    if (limit_hit || halt_det) begin
                        cpu_rst_reg <= 1'b0;
                        timeout_reg <= limit_hit;
                        idx_reg     <= '0;
                        state_reg   <= DUMP_RD;
                    end
                end
                DUMP_RD: begin
                    beat_reg  <= '{idx: idx_reg, data: rf_rdata_i};
                    valid_reg <= 1'b1;
                    state_reg <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (dump_ready_i) begin
                        valid_reg <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= DUMP_RD;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cpu_rst_o    = cpu_rst_reg;
    assign rf_raddr_o   = idx_reg;
    assign dump_valid_o = valid_reg;
    assign dump_idx_o   = beat_reg.idx;
    assign dump_data_o  = beat_reg.data;
    assign cycle_cnt_o  = cnt_reg;
    assign done_o       = done_reg;
    assign timeout_o    = timeout_reg;

endmodule
